// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller: condition codes,
// FSM encoding, prediction-table geometry and small helper functions.
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   localparam int BHT_DEPTH = 16;
   localparam int BHT_IDX_W = 4;

   // Flag polarity follows the ALU compare: c set means "no unsigned less-than".
   function automatic logic cond_taken(input logic [2:0] f3, input logic s, input logic z,
                                       input logic c, input logic v);
      logic t;
      t = 1'b0;
      case (f3)
         F3_BEQ:  t = z;
         F3_BNE:  t = ~z;
         F3_BLT:  t = (s != v);
         F3_BGE:  t = (s == v);
         F3_BLTU: t = ~c;
         F3_BGEU: t = c;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] n;
      n = cnt;
      if (taken) begin
         if (cnt != 2'b11) n = cnt + 2'b01;
      end else begin
         if (cnt != 2'b00) n = cnt - 2'b01;
      end
      return n;
   endfunction

endpackage

// File: rtl/branch_bht.sv
// 16-entry table of 2-bit saturating direction counters with a combinational
// lookup port; a lookup that coincides with an update sees the old value.
module branch_bht
   import branch_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 upd_en,
   input  logic [BHT_IDX_W-1:0] upd_idx,
   input  logic                 upd_taken,
   input  logic [BHT_IDX_W-1:0] rd_idx,
   output logic                 rd_taken
);

   logic [1:0] cnt_all [BHT_DEPTH];

   generate
      for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_ent
         logic [1:0] cnt_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_reg <= 2'b01;
            end else if (upd_en && (upd_idx == BHT_IDX_W'(gi))) begin
               cnt_reg <= sat_update(cnt_reg, upd_taken);
            end
         end

         assign cnt_all[gi] = cnt_reg;
      end
   endgenerate

   assign rd_taken = cnt_all[rd_idx][1];

endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage branch resolution, redirect handshake and flush control.
// Optional direction predictor enabled by defining BRANCH_BHT_EN.
module branch_ctrl
   import branch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_branch,
   input  logic        ex_jump,
   input  logic [2:0]  ex_func3,
   input  logic        flag_s,
   input  logic        flag_z,
   input  logic        flag_c,
   input  logic        flag_v,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_compressed,
   input  logic        ex_pred_taken,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        flush_if,
   output logic        flush_id,
   output logic        stall_ex,
   output logic [15:0] branch_cnt,
   output logic [15:0] mispredict_cnt
);

   state_t      state_reg;
   logic        resolve;
   logic        actual_taken;
   logic        pred_eff;
   logic        mispredict;
   logic [31:0] fallthrough_pc;

   assign resolve        = (state_reg == ST_IDLE) && ex_valid && (ex_branch || ex_jump);
   assign actual_taken   = ex_jump | cond_taken(ex_func3, flag_s, flag_z, flag_c, flag_v);
   assign mispredict     = resolve && (actual_taken != pred_eff);
   assign fallthrough_pc = ex_pc + (ex_compressed ? 32'd2 : 32'd4);

`ifdef BRANCH_BHT_EN
   logic unused_pc_bits;

   // Jumps never predict taken and never train the table.
   assign pred_eff = ex_jump ? 1'b0 : ex_pred_taken;

   branch_bht u_bht (
      .clk       (clk),
      .rst       (rst),
      .upd_en    (resolve && ex_branch && !ex_jump),
      .upd_idx   (ex_pc[BHT_IDX_W:1]),
      .upd_taken (actual_taken),
      .rd_idx    (if_pc[BHT_IDX_W:1]),
      .rd_taken  (if_pred_taken)
   );

   assign unused_pc_bits = ^{if_pc[31:BHT_IDX_W+1], if_pc[0]};
`else
   logic unused_pred_inputs;

   assign pred_eff           = 1'b0;
   assign if_pred_taken      = 1'b0;
   assign unused_pred_inputs = ^{ex_pred_taken, if_pc};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
         flush_if       <= 1'b0;
         flush_id       <= 1'b0;
         stall_ex       <= 1'b0;
         branch_cnt     <= 16'd0;
         mispredict_cnt <= 16'd0;
      end else begin
         if (resolve) begin
            branch_cnt <= branch_cnt + 16'd1;
         end
         if (mispredict) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
         end

         case (state_reg)
            ST_IDLE: begin
               if (mispredict) begin
                  state_reg      <= ST_REDIRECT;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= actual_taken ? ex_target : fallthrough_pc;
                  flush_if       <= 1'b1;
                  flush_id       <= 1'b1;
                  stall_ex       <= 1'b1;
               end
            end
            ST_REDIRECT: begin
               // redirect_pc is only loaded in IDLE, so it holds while fetch stalls.
               if (redirect_ready) begin
                  state_reg      <= ST_DRAIN;
                  redirect_valid <= 1'b0;
                  flush_if       <= 1'b1;
                  flush_id       <= 1'b0;
                  stall_ex       <= 1'b0;
               end
            end
            ST_DRAIN: begin
               state_reg      <= ST_IDLE;
               redirect_valid <= 1'b0;
               flush_if       <= 1'b0;
               flush_id       <= 1'b0;
               stall_ex       <= 1'b0;
            end
            default: begin
               state_reg      <= ST_IDLE;
               redirect_valid <= 1'b0;
               flush_if       <= 1'b0;
               flush_id       <= 1'b0;
               stall_ex       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ex_valid, input, 1, execute-stage instruction valid.
REQ-004 SHALL have ports ex_branch and ex_jump, inputs, 1 each, flagging a conditional branch and an unconditional JAL/JALR respectively.
REQ-005 SHALL have port ex_func3, input, 3, branch condition code.
REQ-006 SHALL have ports flag_s, flag_z, flag_c, flag_v, inputs, 1 each, ALU compare flags.
REQ-007 SHALL have ports ex_pc and ex_target, inputs, 32 each, and ex_compressed, input, 1 (16-bit instruction).
REQ-008 SHALL have port ex_pred_taken, input, 1, the prediction carried from fetch.
REQ-009 SHALL have port if_pc, input, 32, the fetch lookup address, and if_pred_taken, output, 1.
REQ-010 SHALL have ports redirect_valid, output, 1; redirect_pc, output, 32; and redirect_ready, input, 1, from fetch.
REQ-011 SHALL have ports flush_if, flush_id and stall_ex, outputs, 1 each.
REQ-012 SHALL have ports branch_cnt and mispredict_cnt, outputs, 16 each, performance counters.

Function
REQ-013 SHALL compute actual_taken from ex_func3 as follows:
- 000 -> z
- 001 -> ~z
- 100 -> s!=v
- 101 -> s==v
- 110 -> ~c
- 111 -> c
- 010 and 011 -> 0
REQ-014 SHALL treat ex_jump as actual_taken=1, overriding ex_func3.
REQ-015 SHALL resolve only when ex_valid and (ex_branch or ex_jump) are high while in state IDLE; ex inputs SHALL be ignored in all other states.
REQ-016 SHALL declare a mispredict when actual_taken differs from the effective prediction; the effective prediction is ex_pred_taken for branches and 0 for jumps.
REQ-017 SHALL implement three states: IDLE, REDIRECT and DRAIN.
- IDLE -> REDIRECT on mispredict.
- REDIRECT -> DRAIN when redirect_valid and redirect_ready are both high.
- DRAIN -> IDLE unconditionally after one cycle.
REQ-018 SHALL register redirect_pc on entry to REDIRECT:
- actual_taken=1: ex_target.
- actual_taken=0: ex_pc+2 if ex_compressed, else ex_pc+4.
- Arithmetic is modulo 2^32, so 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-019 SHALL assert redirect_valid, flush_if, flush_id and stall_ex throughout REDIRECT, so redirect_valid rises exactly one cycle after the mispredicting resolve.
REQ-020 SHALL hold redirect_pc stable while redirect_valid=1 and redirect_ready=0.
REQ-021 SHALL assert flush_if=1 with stall_ex=0 in DRAIN, and all four of redirect_valid, flush_if, flush_id and stall_ex =0 in IDLE.
REQ-022 SHALL increment branch_cnt on every resolve and mispredict_cnt on every mispredict, both wrapping 0xFFFF->0x0000.

Reset
REQ-023 SHALL, while rst=0 (including mid-REDIRECT), force the following regardless of clk:
- state=IDLE.
- redirect_valid=0, redirect_pc=0.
- flush_if, flush_id, stall_ex =0.
- both counters =0.
- all prediction counters =01.

Configuration
REQ-024 SHALL, with macro BRANCH_BHT_EN defined, include a 16-entry table of 2-bit saturating counters:
- indexed by pc[4:1].
- if_pred_taken = counter[1] at index if_pc[4:1], combinational.
- the entry at ex_pc[4:1] updates on each conditional-branch resolve: +1 if taken, -1 if not, saturating at 00 and 11.
- jumps do not update the table.
REQ-025 SHALL, with BRANCH_BHT_EN defined, have a same-cycle lookup and update to one index return the pre-update value.
REQ-026 SHALL, without BRANCH_BHT_EN, tie if_pred_taken=0 and treat ex_pred_taken as 0.

Structure
REQ-027 SHALL place the func3 condition codes, the state encoding and the table depth/index width in shared package branch_pkg.
REQ-028 SHALL implement the prediction table as sub-module branch_bht, instantiated only under BRANCH_BHT_EN.

Verification
REQ-029 SHALL cover: BEQ, z=1, ex_pred_taken=0, ex_target=0x100 -> next cycle redirect_valid=1, redirect_pc=0x100, flush_if/flush_id/stall_ex=1, mispredict_cnt=1.
REQ-030 SHALL cover: BLTU, c=1, ex_compressed=1, ex_pc=0x200, ex_pred_taken=1 -> redirect_pc=0x202.
REQ-031 SHALL cover: mispredict with redirect_ready held 0 for 3 cycles -> redirect_pc stable for 4 cycles, then DRAIN for 1 cycle with flush_if=1, then IDLE.
REQ-032 SHALL cover: not-taken branch at ex_pc=0xFFFFFFFC, ex_pred_taken=1 -> redirect_pc=0x00000000.
REQ-033 SHALL cover: rst driven low during REDIRECT -> redirect_valid and stall_ex =0 immediately, without a clk edge.
REQ-034 SHALL cover, with BRANCH_BHT_EN: three taken branches at pc 0x40 -> if_pred_taken=1 for if_pc=0x40, and if_pred_taken=0 for if_pc=0x44.
